// File: rtl/coincidence_scan_controller.sv
// coincidence_scan_controller: runs one histogram acquisition on the recorder, reads back every bin, finds each channel's rising edge.
// Latency: after the acquisition ends, CHANNEL_COUNT*(N+1)*(READ_SETTLE+3) cycles to done (+2 when auto-align issues its commands).
// Backpressure: none; start is dropped unless idle, and the recorder's busy flag paces the acquisition wait.
// Ports: sysClk/sysReset_n (async active-low); start/alignChannel request; busy/done/timeoutError/edgeValid status;
//        resultChannel -> resultBin result read mux; csrStrobe/csrData command port out, csrStatus recorder status in.
// Optional macro COINCIDENCE_SCAN_AUTOALIGN_EN: after the scan, program the coincidence point and realign the heartbeat.
module coincidence_scan_controller #(
  parameter int CHANNEL_COUNT               = 2,
  parameter int SAMPLE_CLKS_PER_COINCIDENCE = 16,
  parameter int SUM_WIDTH                   = 10,
  parameter int THRESHOLD                   = 512,
  parameter int READ_SETTLE                 = 8,
  parameter int BUSY_TIMEOUT                = 1023,
  parameter int ALIGN_OFFSET                = 0,
  localparam int MUXSEL_WIDTH               = $clog2(CHANNEL_COUNT),
  localparam int BW                         = $clog2(SAMPLE_CLKS_PER_COINCIDENCE)
) (
  input  logic                     sysClk,
  input  logic                     sysReset_n,
  input  logic                     start,
  input  logic [MUXSEL_WIDTH-1:0]  alignChannel,
  output logic                     busy,
  output logic                     done,
  output logic                     timeoutError,
  output logic [CHANNEL_COUNT-1:0] edgeValid,
  input  logic [MUXSEL_WIDTH-1:0]  resultChannel,
  output logic [BW-1:0]            resultBin,
  output logic                     csrStrobe,
  output logic [31:0]              csrData,
  input  logic [31:0]              csrStatus
);

  localparam int N       = SAMPLE_CLKS_PER_COINCIDENCE;
  localparam int CNT_MAX = (BUSY_TIMEOUT > READ_SETTLE) ? BUSY_TIMEOUT : READ_SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 2);
  localparam logic [SUM_WIDTH-1:0] THR    = SUM_WIDTH'(THRESHOLD);
  // Truncation to BW bits is the mod-N wrap (N is a power of two).
  localparam logic [BW-1:0]        OFFSET = BW'(ALIGN_OFFSET);

  localparam logic [31:0] CMD_ACQ     = 32'h8000_0000;
  localparam logic [31:0] CMD_COINC   = 32'h4000_0000;
  localparam logic [31:0] CMD_REALIGN = 32'h2000_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_ACQ, S_WAIT_HI, S_WAIT_LO, S_READ, S_SETTLE, S_SAMPLE,
`ifdef COINCIDENCE_SCAN_AUTOALIGN_EN
    S_COINC, S_REALIGN,
`endif
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BW:0]              rd_q, rd_d;          // read index 0..N within a channel
  logic [MUXSEL_WIDTH-1:0]  ch_q, ch_d;
  logic [MUXSEL_WIDTH-1:0]  align_ch_q, align_ch_d;
  logic                     prev_hi_q, prev_hi_d;
  logic [CHANNEL_COUNT-1:0] edge_valid_q, edge_valid_d;
  logic [BW-1:0]            result_q [CHANNEL_COUNT];
  logic [BW-1:0]            result_d [CHANNEL_COUNT];
  logic                     timeout_q, timeout_d;
  logic [31:0]              csr_data_q, csr_data_d;

  logic [BW:0]              rd_m1;
  logic [BW-1:0]            cur_bin;
  logic                     cur_hi;
  logic [BW-1:0]            align_bin;
  logic                     csr_strobe;
  logic [31:0]              cmd_word;
  logic                     unused_status;

  // Read 0 fetches bin N-1 to seed "previous"; read k>0 fetches bin k-1.
  assign rd_m1     = rd_q - (BW+1)'(1);
  assign cur_bin   = rd_m1[BW-1:0];
  assign cur_hi    = csrStatus[SUM_WIDTH-1:0] >= THR;
  assign align_bin = result_q[align_ch_q] + OFFSET;

`ifdef COINCIDENCE_SCAN_AUTOALIGN_EN
  assign unused_status = ^csrStatus[30:SUM_WIDTH];
`else
  assign unused_status = ^{csrStatus[30:SUM_WIDTH], align_bin};
`endif

  // State register
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rd_q         <= '0;
      ch_q         <= '0;
      align_ch_q   <= '0;
      prev_hi_q    <= 1'b0;
      edge_valid_q <= '0;
      result_q     <= '{default: '0};
      timeout_q    <= 1'b0;
      csr_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_q         <= rd_d;
      ch_q         <= ch_d;
      align_ch_q   <= align_ch_d;
      prev_hi_q    <= prev_hi_d;
      edge_valid_q <= edge_valid_d;
      result_q     <= result_d;
      timeout_q    <= timeout_d;
      csr_data_q   <= csr_data_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_d         = rd_q;
    ch_d         = ch_q;
    align_ch_d   = align_ch_q;
    prev_hi_d    = prev_hi_q;
    edge_valid_d = edge_valid_q;
    result_d     = result_q;
    timeout_d    = timeout_q;
    // cmd_word already falls back to the held word when no strobe is issued.
    csr_data_d   = cmd_word;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          align_ch_d   = alignChannel;
          edge_valid_d = '0;
          timeout_d    = 1'b0;
          state_d      = S_ACQ;
        end
      end
      S_ACQ: begin
        cnt_d   = '0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (csrStatus[31]) begin
          state_d = S_WAIT_LO;
        end else if (cnt_q >= CNT_W'(BUSY_TIMEOUT)) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_LO: begin
        if (!csrStatus[31]) begin
          rd_d    = '0;
          ch_d    = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        // READ_SETTLE+1 cycles here: a full READ_SETTLE after the strobe cycle before sampling.
        if (cnt_q == CNT_W'(READ_SETTLE)) state_d = S_SAMPLE;
        else                              cnt_d   = cnt_q + CNT_W'(1);
      end
      S_SAMPLE: begin
        prev_hi_d = cur_hi;
        // Only the first low->high transition in scan order is kept.
        if ((rd_q != '0) && !prev_hi_q && cur_hi && !edge_valid_q[ch_q]) begin
          edge_valid_d[ch_q] = 1'b1;
          result_d[ch_q]     = cur_bin;
        end
        if (rd_q == (BW+1)'(N)) begin
          rd_d = '0;
          if (ch_q == MUXSEL_WIDTH'(CHANNEL_COUNT - 1)) begin
`ifdef COINCIDENCE_SCAN_AUTOALIGN_EN
            // Use the _d view so an edge found on this very sample counts.
            state_d = edge_valid_d[align_ch_q] ? S_COINC : S_DONE;
`else
            state_d = S_DONE;
`endif
          end else begin
            ch_d    = ch_q + MUXSEL_WIDTH'(1);
            state_d = S_READ;
          end
        end else begin
          rd_d    = rd_q + (BW+1)'(1);
          state_d = S_READ;
        end
      end
`ifdef COINCIDENCE_SCAN_AUTOALIGN_EN
      S_COINC:   state_d = S_REALIGN;
      S_REALIGN: state_d = S_DONE;
`endif
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    done       = (state_q == S_DONE);
    csr_strobe = 1'b0;
    cmd_word   = csr_data_q;
    case (state_q)
      S_ACQ: begin
        csr_strobe = 1'b1;
        cmd_word   = CMD_ACQ;
      end
      S_READ: begin
        csr_strobe = 1'b1;
        cmd_word   = (32'(ch_q) << 24) | 32'(cur_bin);
      end
`ifdef COINCIDENCE_SCAN_AUTOALIGN_EN
      S_COINC: begin
        csr_strobe = 1'b1;
        cmd_word   = CMD_COINC | 32'(align_bin);
      end
      S_REALIGN: begin
        csr_strobe = 1'b1;
        cmd_word   = CMD_REALIGN;
      end
`endif
      default: ;
    endcase
  end

  assign csrStrobe    = csr_strobe;
  assign csrData      = cmd_word;
  assign timeoutError = timeout_q;
  assign edgeValid    = edge_valid_q;
  assign resultBin    = result_q[resultChannel];

endmodule

// File: tb/tb_coincidence_scan_controller.sv
// tb_coincidence_scan_controller: bench for coincidence_scan_controller with a behavioural recorder.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_coincidence_scan_controller;
  localparam int CH = 2;
  localparam int NB = 16;
  localparam int AO = 12;

  logic        sysClk = 1'b0;
  logic        sysReset_n = 1'b0;
  logic        start = 1'b0;
  logic [0:0]  alignChannel = 1'b0;
  logic [0:0]  resultChannel = 1'b0;
  logic        busy, done, timeoutError;
  logic [1:0]  edgeValid;
  logic [3:0]  resultBin;
  logic        csrStrobe;
  logic [31:0] csrData;
  logic [31:0] csrStatus;

  always #5 sysClk = ~sysClk;

  coincidence_scan_controller #(
    .CHANNEL_COUNT(CH), .SAMPLE_CLKS_PER_COINCIDENCE(NB), .SUM_WIDTH(10),
    .THRESHOLD(512), .READ_SETTLE(8), .BUSY_TIMEOUT(1023), .ALIGN_OFFSET(AO)
  ) dut (
    .sysClk(sysClk), .sysReset_n(sysReset_n), .start(start), .alignChannel(alignChannel),
    .busy(busy), .done(done), .timeoutError(timeoutError), .edgeValid(edgeValid),
    .resultChannel(resultChannel), .resultBin(resultBin), .csrStrobe(csrStrobe),
    .csrData(csrData), .csrStatus(csrStatus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Recorder model: histogram memory, read-select latch, acquisition busy window.
  logic [9:0] hist [CH][NB];
  bit         never_busy = 1'b0;
  int         acq_t = 0;
  logic       rd_ch = 1'b0;
  logic [3:0] rd_bin = 4'd0;
  logic       acq_busy;

  always @(posedge sysClk) begin
    if (csrStrobe && csrData == 32'h8000_0000 && !never_busy) acq_t <= 1;
    else if (acq_t > 0 && acq_t < 40)                          acq_t <= acq_t + 1;
    else                                                       acq_t <= 0;
    if (csrStrobe && csrData[31:29] == 3'b000) begin
      rd_ch  <= csrData[24];
      rd_bin <= csrData[3:0];
    end
  end
  assign acq_busy  = (acq_t >= 3) && (acq_t < 40);
  assign csrStatus = {acq_busy, 21'd0, hist[rd_ch][rd_bin]};

  // Scoreboard of expected command words, consumed as strobes appear.
  logic [31:0] exp_q [$];
  logic [31:0] last_w = 32'd0;
  int cyc = 0;
  int first_rd_cyc = -1;
  int acq_cyc = -1;

  always @(posedge sysClk) cyc <= cyc + 1;

  always @(negedge sysClk) begin
    if (!sysReset_n) begin
      last_w = 32'd0;
    end else if (csrStrobe) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL strobe_unexpected: got csrData=0x%0h, required no strobe", csrData);
      end else begin
        chk("strobe_word", csrData, exp_q.pop_front());
      end
      if (csrData[31:29] == 3'b000 && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (csrData == 32'h8000_0000) acq_cyc = cyc;
      last_w = csrData;
    end else begin
      chk("csrData_hold", csrData, last_w);
    end
  end

  typedef struct {
    logic [15:0] m0;
    logic [15:0] m1;
    logic [9:0]  hi;
    logic [9:0]  lo;
    logic [0:0]  align;
    logic [1:0]  ev;
    logic [3:0]  b0;
    logic [3:0]  b1;
  } rec_t;
  rec_t tbl [5];

  task automatic load_hist(input rec_t r);
    for (int b = 0; b < NB; b++) begin
      hist[0][b] = r.m0[b] ? r.hi : r.lo;
      hist[1][b] = r.m1[b] ? r.hi : r.lo;
    end
  endtask

  task automatic pulse_start(input logic [0:0] a);
    @(negedge sysClk);
    alignChannel = a;
    start = 1'b1;
    @(negedge sysClk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge sysClk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_wait: got no done within %0d cycles, required a done pulse", budget);
    end
  endtask

  task automatic push_scan(input rec_t r, output int exp_len);
    logic [3:0] ab;
    exp_q.delete();
    exp_q.push_back(32'h8000_0000);
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k <= NB; k++) begin
        exp_q.push_back((32'(c) << 24) | 32'((k == 0) ? NB - 1 : k - 1));
      end
    end
    exp_len = CH * (NB + 1) * 11;
    ab = 4'd0;
`ifdef COINCIDENCE_SCAN_AUTOALIGN_EN
    if (r.ev[r.align]) begin
      ab = ((r.align == 1'b1) ? r.b1 : r.b0) + 4'(AO);
      exp_q.push_back(32'h4000_0000 | 32'(ab));
      exp_q.push_back(32'h2000_0000);
      exp_len = exp_len + 2;
    end
`endif
  endtask

  task automatic run_scan(input rec_t r);
    bit ok;
    int exp_len;
    load_hist(r);
    push_scan(r, exp_len);
    first_rd_cyc = -1;
    pulse_start(r.align);
    chk("busy_after_start", busy, 1);
    chk("timeout_cleared", timeoutError, 0);
    chk("edge_valid_cleared", edgeValid, 0);
    repeat (40) @(negedge sysClk);
    // A second request while busy must be dropped, with a different align channel.
    start = 1'b1;
    alignChannel = ~r.align;
    @(negedge sysClk);
    start = 1'b0;
    alignChannel = r.align;
    wait_done(1000, ok);
    if (ok) begin
      chk("busy_at_done", busy, 0);
      chk("scan_len", cyc - first_rd_cyc, exp_len);
      chk("edge_valid", edgeValid, r.ev);
      chk("timeout_flag", timeoutError, 0);
      resultChannel = 1'b0;
      #1;
      chk("result_bin_ch0", resultBin, r.b0);
      resultChannel = 1'b1;
      #1;
      chk("result_bin_ch1", resultBin, r.b1);
      @(negedge sysClk);
      chk("done_one_cycle", done, 0);
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    bit ok;
    int exp_len;
    //          m0        m1        hi     lo    align ev     b0    b1
    tbl[0] = '{16'hFFC0, 16'h000F, 10'd1023, 10'd0,   1'b0, 2'b11, 4'd6, 4'd0};
    tbl[1] = '{16'hFFFF, 16'h0000, 10'd1023, 10'd0,   1'b0, 2'b00, 4'd6, 4'd0};
    tbl[2] = '{16'h0F00, 16'h8001, 10'd512,  10'd511, 1'b1, 2'b11, 4'd8, 4'd15};
    tbl[3] = '{16'h5030, 16'h0002, 10'd700,  10'd100, 1'b0, 2'b11, 4'd4, 4'd1};
    tbl[4] = '{16'h0000, 16'hFFF0, 10'd1023, 10'd0,   1'b1, 2'b10, 4'd4, 4'd4};
    load_hist(tbl[0]);

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeoutError, 0);
    chk("rst_edge_valid", edgeValid, 0);
    chk("rst_result_bin", resultBin, 0);
    chk("rst_strobe", csrStrobe, 0);
    chk("rst_csr_data", csrData, 0);
    @(negedge sysClk);
    sysReset_n = 1'b1;
    repeat (3) @(negedge sysClk);

    for (int i = 0; i < 5; i++) run_scan(tbl[i]);

    // Recorder never goes busy: timeout after the full wait, no reads.
    never_busy = 1'b1;
    exp_q.delete();
    exp_q.push_back(32'h8000_0000);
    acq_cyc = -1;
    pulse_start(1'b0);
    wait_done(1200, ok);
    if (ok) begin
      chk("to_len", cyc - acq_cyc, 1025);
      chk("to_flag", timeoutError, 1);
      chk("to_edge_valid", edgeValid, 0);
      chk("to_busy", busy, 0);
      @(negedge sysClk);
      chk("to_flag_held", timeoutError, 1);
    end
    chk("to_queue_drained", exp_q.size(), 0);
    never_busy = 1'b0;
    repeat (5) @(negedge sysClk);
    run_scan(tbl[0]);

    // Reset during SETTLE of the first read, then a full rescan.
    load_hist(tbl[0]);
    push_scan(tbl[0], exp_len);
    first_rd_cyc = -1;
    pulse_start(1'b0);
    for (int k = 0; k < 200 && first_rd_cyc < 0; k++) @(negedge sysClk);
    chk("mid_first_read_seen", first_rd_cyc >= 0, 1);
    repeat (3) @(negedge sysClk);
    #2;
    sysReset_n = 1'b0;
    resultChannel = 1'b0;
    #1;
    chk("mid_rst_strobe", csrStrobe, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_csr_data", csrData, 0);
    chk("mid_rst_result_bin", resultBin, 0);
    chk("mid_rst_edge_valid", edgeValid, 0);
    exp_q.delete();
    repeat (3) @(negedge sysClk);
    sysReset_n = 1'b1;
    repeat (50) @(negedge sysClk);
    run_scan(tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
